nand_flash_responder: RTL and testbench

//   Device-side model of the 8-bit NAND flash that NFC-style hosts drive. Decodes CLE/ALE/WEN

---
 rtl/nand_pkg.sv | 33 +++
 rtl/nand_page_array.sv | 48 ++++
 rtl/nand_flash_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_nand_flash_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// Shared command codes, FSM state encoding and default geometry for the NAND flash responder.
package nand_pkg;

    localparam int PAGE_BYTES_DEF = 512;
    localparam int NUM_PAGES_DEF  = 512;

    localparam logic [7:0] CMD_READ      = 8'h00;
    localparam logic [7:0] CMD_PROG      = 8'h80;
    localparam logic [7:0] CMD_PROG_CONF = 8'h10;
    localparam logic [7:0] CMD_RESET     = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD_BUSY,
        ST_RD_OUT,
        ST_PG_DATA,
        ST_PG_BUSY,
        ST_RST_BUSY
    } state_t;

    // Where a command lands when the device is ready to accept a fresh one.
    function automatic state_t decode_cmd(input logic [7:0] cmd);
        state_t nxt;
        case (cmd)
            CMD_READ, CMD_PROG: nxt = ST_ADDR;
            CMD_RESET:          nxt = ST_RST_BUSY;
            default:            nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/nand_page_array.sv
// Flash cell array (sync single-port RAM, 1-clk read, no reset) plus the page register (flops, async read).
// Latency: array read data valid the clk after the address; page register reads are combinational.
// Backpressure: none; the controller sequences every access and owns all enables.
module nand_page_array
    import nand_pkg::*;
#(
    parameter int PAGE_BYTES = PAGE_BYTES_DEF,
    parameter int NUM_PAGES  = NUM_PAGES_DEF,
    parameter int ROW_BITS   = 9,
    parameter int COL_W      = $clog2(PAGE_BYTES)
) (
    input  logic                      clk,
    input  logic                      arr_we,
    input  logic [ROW_BITS+COL_W-1:0] arr_addr,
    input  logic [7:0]                arr_wdat,
    output logic [7:0]                arr_rdat,
    input  logic                      buf_fill,
    input  logic                      buf_we,
    input  logic [COL_W-1:0]          buf_waddr,
    input  logic [7:0]                buf_wdat,
    input  logic [COL_W-1:0]          buf_raddr,
    output logic [7:0]                buf_rdat
);

    logic [7:0] mem      [NUM_PAGES*PAGE_BYTES];
    logic [7:0] page_buf [PAGE_BYTES];

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_wdat;
        end
        arr_rdat <= mem[arr_addr];
    end

    // Whole-page preset happens in one clk when a program command is accepted.
    always_ff @(posedge clk) begin
        if (buf_fill) begin
            for (int i = 0; i < PAGE_BYTES; i++) begin
                page_buf[i] <= 8'hFF;
            end
        end else if (buf_we) begin
            page_buf[buf_waddr] <= buf_wdat;
        end
    end

    assign buf_rdat = page_buf[buf_raddr];

endmodule

// File: rtl/nand_flash_responder.sv
// NAND flash device model: decodes CLE/ALE/WEN cycles, runs page read, page program and reset.
// Latency: F_RB falls the clk after the command's WEN edge; read busy = PAGE_BYTES+1+T_RD_BUSY clks.
// Backpressure: host polls F_RB; WEN/REN events while busy are dropped except CMD 0xFF.
module nand_flash_responder
    import nand_pkg::*;
#(
    parameter int PAGE_BYTES = PAGE_BYTES_DEF,
    parameter int NUM_PAGES  = NUM_PAGES_DEF,
    parameter int ROW_BITS   = 9,
    parameter int T_RD_BUSY  = 16,
    parameter int T_PG_BUSY  = 64,
    parameter int T_RST_BUSY = 8
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] F_IO,
    input  logic       F_CLE,
    input  logic       F_ALE,
    input  logic       F_REN,
    input  logic       F_WEN,
    output logic       F_RB
);

    localparam int COL_W    = $clog2(PAGE_BYTES);
    localparam int PTR_W    = COL_W + 1;
    localparam int CNT_W    = $clog2(PAGE_BYTES + T_RD_BUSY + T_PG_BUSY + T_RST_BUSY + 2);
    localparam int RD_LAST  = PAGE_BYTES + T_RD_BUSY;
    localparam int PG_LAST  = PAGE_BYTES + T_PG_BUSY;
    localparam int RST_LAST = T_RST_BUSY - 1;

    state_t              state;
    state_t              state_d;
    logic [7:0]          io_q;
    logic                cle_q;
    logic                ale_q;
    logic                wen_q;
    logic                ren_q;
    logic                is_prog;
    logic [1:0]          addr_cnt;
    logic [7:0]          col;
    logic [ROW_BITS-1:0] row;
    logic [PTR_W-1:0]    ptr;
    logic [CNT_W-1:0]    cnt;

    logic                wen_vld;
    logic                cmd_vld;
    logic                addr_vld;
    logic                data_vld;
    logic                ren_vld;
    logic                ptr_end;
    logic                busy;
    logic                cmd_acc;
    logic                ptr_inc;
    logic                ptr_load;

    logic                arr_we;
    logic [7:0]          arr_rdat;
    logic                buf_fill;
    logic                buf_we;
    logic [COL_W-1:0]    buf_waddr;
    logic [7:0]          buf_wdat;
    logic [COL_W-1:0]    buf_raddr;
    logic [7:0]          buf_rdat;
    logic                io_oe;
    logic [7:0]          io_dat;

    // Events fire on the rising strobe but use bus values captured while the strobe was low.
    assign wen_vld  = F_WEN & ~wen_q;
    assign ren_vld  = F_REN & ~ren_q;
    assign cmd_vld  = wen_vld & cle_q & ~ale_q;
    assign addr_vld = wen_vld & ale_q & ~cle_q;
    assign data_vld = wen_vld & ~cle_q & ~ale_q;
    assign ptr_end  = (ptr >= PTR_W'(PAGE_BYTES));
    assign busy     = (state == ST_RD_BUSY) || (state == ST_PG_BUSY) || (state == ST_RST_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            io_q  <= 8'h00;
            cle_q <= 1'b0;
            ale_q <= 1'b0;
            wen_q <= 1'b1;
            ren_q <= 1'b1;
        end else begin
            io_q  <= F_IO;
            cle_q <= F_CLE;
            ale_q <= F_ALE;
            wen_q <= F_WEN;
            ren_q <= F_REN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cmd_acc   = 1'b0;
        ptr_inc   = 1'b0;
        arr_we    = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = ptr[COL_W-1:0];
        buf_wdat  = io_q;
        unique case (state)
            ST_IDLE: begin
                if (cmd_vld) begin
                    cmd_acc = 1'b1;
                    state_d = decode_cmd(io_q);
                end
            end
            ST_ADDR: begin
                if (cmd_vld) begin
                    cmd_acc = 1'b1;
                    state_d = decode_cmd(io_q);
                end else if (addr_vld && addr_cnt == 2'd2) begin
                    state_d = is_prog ? ST_PG_DATA : ST_RD_BUSY;
                end
            end
            ST_RD_BUSY: begin
                if (cmd_vld && io_q == CMD_RESET) begin
                    cmd_acc = 1'b1;
                    state_d = ST_RST_BUSY;
                end else if (cnt == CNT_W'(RD_LAST)) begin
                    state_d = ST_RD_OUT;
                end
                // Array data trails its address by one clk, so byte k lands while cnt == k+1.
                if (cnt != '0 && cnt <= CNT_W'(PAGE_BYTES)) begin
                    buf_we    = 1'b1;
                    buf_waddr = COL_W'(cnt - 1'b1);
                    buf_wdat  = arr_rdat;
                end
            end
            ST_RD_OUT: begin
                if (cmd_vld) begin
                    cmd_acc = 1'b1;
                    state_d = decode_cmd(io_q);
                end else if (ren_vld && !ptr_end) begin
                    ptr_inc = 1'b1;
                end
            end
            ST_PG_DATA: begin
                if (cmd_vld) begin
                    cmd_acc = 1'b1;
                    state_d = (io_q == CMD_PROG_CONF) ? ST_PG_BUSY : decode_cmd(io_q);
                end else if (data_vld && !ptr_end) begin
                    buf_we  = 1'b1;
                    ptr_inc = 1'b1;
                end
            end
            ST_PG_BUSY: begin
                if (cmd_vld && io_q == CMD_RESET) begin
                    cmd_acc = 1'b1;
                    state_d = ST_RST_BUSY;
                end else if (cnt == CNT_W'(PG_LAST)) begin
                    state_d = ST_IDLE;
                end
                arr_we = (cnt < CNT_W'(PAGE_BYTES));
            end
            ST_RST_BUSY: begin
                if (cmd_vld && io_q == CMD_RESET) begin
                    cmd_acc = 1'b1;
                end else if (cnt == CNT_W'(RST_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign buf_fill = cmd_acc && (state_d == ST_ADDR) && (io_q == CMD_PROG);
    assign ptr_load = ((state == ST_ADDR) && (state_d == ST_PG_DATA)) ||
                      ((state == ST_RD_BUSY) && (state_d == ST_RD_OUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            is_prog  <= 1'b0;
            addr_cnt <= 2'd0;
            col      <= 8'h00;
            row      <= '0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            if (cmd_acc) begin
                is_prog  <= (io_q == CMD_PROG);
                addr_cnt <= 2'd0;
            end else if (state == ST_ADDR && addr_vld) begin
                addr_cnt <= addr_cnt + 2'd1;
                case (addr_cnt)
                    2'd0:    col      <= io_q;
                    2'd1:    row[7:0] <= io_q;
                    default: row      <= ROW_BITS'({io_q, row[7:0]});
                endcase
            end

            if (ptr_load) begin
                ptr <= PTR_W'(col);
            end else if (ptr_inc) begin
                ptr <= ptr + 1'b1;
            end

            // A reset command during reset-busy restarts the timer.
            if (cmd_acc || state_d != state) begin
                cnt <= '0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign buf_raddr = (state == ST_PG_BUSY) ? cnt[COL_W-1:0] : ptr[COL_W-1:0];

    nand_page_array #(
        .PAGE_BYTES (PAGE_BYTES),
        .NUM_PAGES  (NUM_PAGES),
        .ROW_BITS   (ROW_BITS),
        .COL_W      (COL_W)
    ) u_array (
        .clk       (clk),
        .arr_we    (arr_we),
        .arr_addr  ({row, cnt[COL_W-1:0]}),
        .arr_wdat  (buf_rdat),
        .arr_rdat  (arr_rdat),
        .buf_fill  (buf_fill),
        .buf_we    (buf_we),
        .buf_waddr (buf_waddr),
        .buf_wdat  (buf_wdat),
        .buf_raddr (buf_raddr),
        .buf_rdat  (buf_rdat)
    );

    assign io_oe  = (state == ST_RD_OUT) && !F_REN;
    assign io_dat = ptr_end ? 8'hFF : buf_rdat;
    assign F_IO   = io_oe ? io_dat : 8'bz;
    assign F_RB   = ~busy;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Host-side bench: drives NFC-style cycles, checks F_RB timing and read data against a page-level model.
module tb_nand_flash_responder;

    localparam int PB     = 512;
    localparam int RD_BSY = PB + 1 + 16;
    localparam int PG_BSY = PB + 1 + 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       f_cle;
    logic       f_ale;
    logic       f_ren;
    logic       f_wen;
    logic       f_rb;
    wire  [7:0] f_io;
    logic       host_oe;
    logic [7:0] host_dat;

    assign f_io = host_oe ? host_dat : 8'bz;

    always #5 clk = ~clk;

    nand_flash_responder dut (
        .clk   (clk),
        .rst   (rst),
        .F_IO  (f_io),
        .F_CLE (f_cle),
        .F_ALE (f_ale),
        .F_REN (f_ren),
        .F_WEN (f_wen),
        .F_RB  (f_rb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: flash contents per page, updated whenever a full program completes.
    logic [7:0] model_mem [512][512];

    typedef struct {
        logic       cle;
        logic       ale;
        logic [7:0] dat;
        int         busy;
        string      name;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Each host cycle starts and ends just after a falling clk edge.
    task automatic wen_cycle(input logic cle, input logic ale, input logic [7:0] dat);
        f_cle    = cle;
        f_ale    = ale;
        host_dat = dat;
        host_oe  = 1'b1;
        f_wen    = 1'b0;
        @(negedge clk);
        f_wen = 1'b1;
        @(negedge clk);
        f_cle   = 1'b0;
        f_ale   = 1'b0;
        host_oe = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] c);
        wen_cycle(1'b1, 1'b0, c);
    endtask

    task automatic adr(input logic [7:0] a);
        wen_cycle(1'b0, 1'b1, a);
    endtask

    task automatic send_addr(input int row, input int col);
        adr(8'(col));
        adr(8'(row));
        adr(8'(row >> 8));
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (f_rb == 1'b0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic ren_read(output logic [7:0] v);
        f_ren = 1'b0;
        @(negedge clk);
        v     = f_io;
        f_ren = 1'b1;
        @(negedge clk);
    endtask

    task automatic host_program(input int row, input int col, input logic [7:0] d [$], input string tag);
        int n;
        cmd(8'h80);
        send_addr(row, col);
        foreach (d[k]) wen_cycle(1'b0, 1'b0, d[k]);
        cmd(8'h10);
        check({tag, " prog rb fall"}, 32'(f_rb), 32'd0);
        busy_len(n);
        check({tag, " prog busy len"}, n, PG_BSY);
        for (int p = 0; p < PB; p++) model_mem[row][p] = 8'hFF;
        foreach (d[k]) if (col + k < PB) model_mem[row][col + k] = d[k];
    endtask

    task automatic host_read(input int row, input int col, input int nrd, input string tag);
        int         n;
        logic [7:0] v;
        logic [7:0] e;
        cmd(8'h00);
        send_addr(row, col);
        check({tag, " read rb fall"}, 32'(f_rb), 32'd0);
        busy_len(n);
        check({tag, " read busy len"}, n, RD_BSY);
        for (int k = 0; k < nrd; k++) begin
            ren_read(v);
            e = (col + k < PB) ? model_mem[row][col + k] : 8'hFF;
            check($sformatf("%s byte %0d", tag, col + k), 32'(v), 32'(e));
        end
    endtask

    initial begin
        int         n;
        logic [7:0] q [$];

        rst      = 1'b1;
        f_cle    = 1'b0;
        f_ale    = 1'b0;
        f_ren    = 1'b1;
        f_wen    = 1'b1;
        host_oe  = 1'b0;
        host_dat = 8'h00;
        repeat (3) @(negedge clk);
        check("reset rb", 32'(f_rb), 32'd1);
        host_oe  = 1'b1;
        host_dat = 8'h5A;
        f_ren    = 1'b0;
        #1;
        check("reset io hi-z", 32'(f_io), 32'h5A);
        @(negedge clk);
        host_oe = 1'b0;
        f_ren   = 1'b1;
        rst     = 1'b0;
        @(negedge clk);

        // Single cycles from IDLE: only CMD 0xFF may make the device busy.
        tbl[0] = '{1'b1, 1'b1, 8'hFF, 0, "cle_ale_both_ff"};
        tbl[1] = '{1'b1, 1'b0, 8'h90, 0, "cmd_90_unknown"};
        tbl[2] = '{1'b0, 1'b0, 8'hFF, 0, "data_in_idle"};
        tbl[3] = '{1'b0, 1'b1, 8'hFF, 0, "addr_in_idle"};
        tbl[4] = '{1'b1, 1'b0, 8'h10, 0, "cmd_10_in_idle"};
        tbl[5] = '{1'b1, 1'b0, 8'hFF, 8, "cmd_ff_reset"};
        tbl[6] = '{1'b1, 1'b1, 8'h00, 0, "cle_ale_both_00"};
        for (int i = 0; i < 7; i++) begin
            wen_cycle(tbl[i].cle, tbl[i].ale, tbl[i].dat);
            busy_len(n);
            check(tbl[i].name, n, tbl[i].busy);
        end

        q = {};
        for (int i = 0; i < PB; i++) q.push_back(8'(i));
        host_program(5, 0, q, "t1");
        host_read(5, 0, PB, "t1");

        q = {};
        for (int i = 0; i < PB; i++) q.push_back(8'hA5 ^ 8'(i));
        host_program(298, 0, q, "t2");
        host_read(298, 0, PB, "t2");

        q = {8'h11, 8'h22, 8'h33, 8'h44};
        host_program(3, 16, q, "t3");
        host_read(3, 0, PB + 4, "t3");

        // Reset command aborting an in-progress array copy.
        cmd(8'h80);
        send_addr(7, 0);
        for (int i = 0; i < 8; i++) wen_cycle(1'b0, 1'b0, 8'(i + 1));
        cmd(8'h10);
        repeat (100) @(negedge clk);
        check("t4 mid copy busy", 32'(f_rb), 32'd0);
        cmd(8'hFF);
        busy_len(n);
        check("t4 abort reset busy", n, 8);
        cmd(8'hFF);
        cmd(8'h00);
        busy_len(n);
        check("t4 cmd during busy ignored", n, 6);
        send_addr(5, 0);
        busy_len(n);
        check("t4 still idle", n, 0);

        // Reset while data is being driven.
        cmd(8'h00);
        send_addr(298, 0);
        busy_len(n);
        f_ren = 1'b0;
        @(negedge clk);
        check("t5 io driven", 32'(f_io), 32'hA5);
        rst = 1'b1;
        @(negedge clk);
        host_oe  = 1'b1;
        host_dat = 8'h00;
        #1;
        check("t5 io hi-z after rst", 32'(f_io), 32'h00);
        check("t5 rb after rst", 32'(f_rb), 32'd1);
        @(negedge clk);
        rst     = 1'b0;
        host_oe = 1'b0;
        f_ren   = 1'b1;
        @(negedge clk);
        host_read(5, 3, 4, "t5 post");

        for (int it = 0; it < 6; it++) begin
            int row;
            int col;
            int len;
            int rrow;
            int rcol;
            row = int'($urandom_range(0, 511));
            col = int'($urandom_range(0, 255));
            len = int'($urandom_range(0, 300));
            q = {};
            for (int k = 0; k < len; k++) q.push_back(8'($urandom_range(0, 255)));
            host_program(row, col, q, $sformatf("rnd%0d", it));
            rrow = (it % 2 == 1) ? 5 : row;
            rcol = int'($urandom_range(0, 255));
            host_read(rrow, rcol, PB - rcol + int'($urandom_range(0, 3)), $sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
